// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================
// muldiv_pkg : op/state types and abs helper for muldiv_unit
// Rev 1.0
// ============================================================
package muldiv_pkg;

  localparam int c_MAX_W = 64;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10,
    S_DZ   = 2'b11
  } state_e;

  // Callers sign-extend to c_MAX_W and truncate the result to their width.
  function automatic logic [c_MAX_W-1:0] abs_val(input logic [c_MAX_W-1:0] x);
    return x[c_MAX_W-1] ? (~x + 1'b1) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================
// muldiv_step : one combinational shift-add / restoring-divide step
// Rev 1.0
// ============================================================
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic               div_mode_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  // Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    w_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, operand_i};
    w_diff = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, operand_i};
    acc_o  = acc_i;
    if (div_mode_i) begin
      if (!w_diff[WIDTH]) begin
        acc_o = {w_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_i[0]) begin
        acc_o = {w_sum, acc_i[WIDTH-1:1]};
      end else begin
        acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================
// muldiv_unit : iterative MULT/MULTU/DIV/DIVU with Hi/Lo registers
// Rev 1.0
// ============================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               w_signed_i;
  logic               w_div_i;
  logic               w_div_q;
  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [2*WIDTH-1:0] w_step;
  logic [2*WIDTH-1:0] w_prod;

  assign w_signed_i = ~op_i[0];
  assign w_div_i    = op_i[1];
  assign w_div_q    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign w_ma = w_signed_i ? WIDTH'(abs_val(c_MAX_W'($signed(a_i)))) : a_i;
  assign w_mb = w_signed_i ? WIDTH'(abs_val(c_MAX_W'($signed(b_i)))) : b_i;
  assign w_prod = neg_q ? -acc_q : acc_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i      (acc_q),
    .operand_i  (opnd_q),
    .div_mode_i (w_div_q),
    .acc_o      (w_step)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i && !flush_i) begin
          op_d   = op_e'(op_i);
          neg_d  = w_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rneg_d = w_signed_i & w_div_i & a_i[WIDTH-1];
          cnt_d  = CNT_W'(WIDTH - 1);
          if (w_div_i) begin
            acc_d  = {{WIDTH{1'b0}}, w_ma};
            opnd_d = w_mb;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, w_mb};
            opnd_d = w_ma;
          end
          state_d = (w_div_i && (b_i == '0)) ? S_DZ : S_RUN;
        end
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = w_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          done_d = 1'b1;
          if (w_div_q) begin
            lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
            hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end else begin
            {hi_d, lo_d} = w_prod;
          end
        end
      end
      S_DZ: begin
        state_d = S_IDLE;
        if (!flush_i) begin
          done_d = 1'b1;
          dz_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign div_zero_o = dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================
// tb_muldiv_unit : table, hand-sequence and random checks of muldiv_unit
// Rev 1.0
// ============================================================
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         flush = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock_i    (clock),
    .reset_i    (reset),
    .start_i    (start),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .flush_i    (flush),
    .hi_we_i    (hi_we),
    .lo_we_i    (lo_we),
    .wdata_i    (wdata),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (div_zero),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Architectural reference: plain 64-bit arithmetic, SV division truncates toward zero.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                inout logic [W-1:0] h, inout logic [W-1:0] l, output logic dz);
    longint sx, sy, q, r;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    dz = 1'b0;
    case (o)
      2'b00: begin q = sx * sy; {h, l} = q; end
      2'b01: begin p = ux * uy; {h, l} = p; end
      2'b10: begin
        if (y == 0) dz = 1'b1;
        else begin q = sx / sy; r = sx % sy; l = q[W-1:0]; h = r[W-1:0]; end
      end
      default: begin
        if (y == 0) dz = 1'b1;
        else begin p = ux / uy; l = p[W-1:0]; p = ux % uy; h = p[W-1:0]; end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic hw, input logic lw, input logic [W-1:0] wd, input string tag);
    int lat;
    logic edz;
    logic [W-1:0] eh, el;
    eh = hw ? wd : m_hi;
    el = lw ? wd : m_lo;
    model(o, x, y, eh, el, edz);
    op = o; a = x; b = y; hi_we = hw; lo_we = lw; wdata = wd; start = 1'b1;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check({tag, " busy"}, {63'b0, busy}, 64'd1);
    check({tag, " done low at accept"}, {63'b0, done}, 64'd0);
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, edz ? 64'd1 : 64'(W + 1));
    check({tag, " div_zero"}, {63'b0, div_zero}, {63'b0, edz});
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, dcount;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;

    tbl[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    tbl[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[2]  = '{2'b00, 32'h00000000, 32'h00000007, 32'h00000000, 32'h00000000};
    tbl[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[5]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    tbl[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[8]  = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
    tbl[9]  = '{2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    tbl[10] = '{2'b11, 32'd5,        32'd9,        32'd5,        32'd0};
    tbl[11] = '{2'b10, 32'h80000000, 32'd1,        32'd0,        32'h80000000};

    // Reset state
    tick(); tick();
    check("reset busy", {63'b0, busy}, 0);
    check("reset done", {63'b0, done}, 0);
    check("reset div_zero", {63'b0, div_zero}, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    reset = 1'b0;
    tick();

    // Table vectors, issued back to back in each done cycle
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0, '0, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d table hi", i), hi, tbl[i].hi);
      check($sformatf("tbl%0d table lo", i), lo, tbl[i].lo);
    end
    tick();
    check("done falls after pulse", {63'b0, done}, 0);

    // Preload and divide by zero
    hi_we = 1'b1; wdata = 32'h1234; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678; tick();
    lo_we = 1'b0;
    m_hi = 32'h1234; m_lo = 32'h5678;
    check("preload hi", hi, 32'h1234);
    check("preload lo", lo, 32'h5678);
    run_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0, '0, "divu0");
    tick();
    check("dz done falls", {63'b0, done}, 0);
    check("dz flag falls", {63'b0, div_zero}, 0);

    // Ignored start while busy, then flush in RUN
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    check("busy before flush", {63'b0, busy}, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush busy", {63'b0, busy}, 0);
    check("flush done", {63'b0, done}, 0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dcount++;
      tick();
    end
    check("no activity after flush", dcount, 0);
    check("flush hi kept", hi, m_hi);
    check("flush lo kept", lo, m_lo);

    // Same divide, hi_we and start while busy are ignored
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    hi_we = 1'b1; wdata = 32'hDEADBEEF; op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1;
    tick();
    hi_we = 1'b0; start = 1'b0;
    check("busy hi_we ignored", hi, m_hi);
    lat = 5;
    while (!done && lat < 100) begin tick(); lat++; end
    check("divu latency", lat, W + 1);
    check("divu hi", hi, 32'd2);
    check("divu lo", lo, 32'd14);
    m_hi = 32'd2; m_lo = 32'd14;

    // Flush in IDLE drops start
    flush = 1'b1; start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3; tick();
    flush = 1'b0; start = 1'b0;
    check("idle flush drops start", {63'b0, busy}, 0);

    // Flush in FIN beats completion
    op = 2'b00; a = 32'd6; b = 32'd9; start = 1'b1; tick(); start = 1'b0;
    repeat (W) tick();
    check("busy in FIN", {63'b0, busy}, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("fin flush done", {63'b0, done}, 0);
    check("fin flush busy", {63'b0, busy}, 0);
    check("fin flush hi", hi, m_hi);
    check("fin flush lo", lo, m_lo);

    // Flush in DZ suppresses flags
    op = 2'b10; a = 32'd9; b = 32'd0; start = 1'b1; tick(); start = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    check("dz flush done", {63'b0, done}, 0);
    check("dz flush flag", {63'b0, div_zero}, 0);

    // Start together with direct writes
    run_op(2'b01, 32'd11, 32'd13, 1'b1, 1'b1, 32'hCAFE0001, "start+we");
    run_op(2'b11, 32'd11, 32'd0, 1'b1, 1'b0, 32'hBEEF0002, "dz+we");

    // Randomised operations against the model
    for (int i = 0; i < 30; i++) begin
      int gap;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom();
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom();
      endcase
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        hi_we = 1'($urandom_range(0, 1));
        lo_we = 1'($urandom_range(0, 1));
        wdata = $urandom();
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
      end
      run_op(ro, ra, rb, 1'b0, 1'b0, '0, $sformatf("rnd%0d op%0d", i, ro));
    end

    // Asynchronous reset mid-operation
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA5555; tick();
    hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = 32'h1234; b = 32'h5678; start = 1'b1; tick(); start = 1'b0;
    repeat (11) tick();
    #2 reset = 1'b1;
    #1;
    check("async rst busy", {63'b0, busy}, 0);
    check("async rst done", {63'b0, done}, 0);
    check("async rst hi", hi, 0);
    check("async rst lo", lo, 0);
    m_hi = '0; m_lo = '0;
    tick();
    reset = 1'b0;
    tick();
    run_op(2'b00, 32'd6, 32'd7, 1'b0, 1'b0, '0, "post-reset mult");
    check("post-reset lo 42", lo, 32'd42);
    check("post-reset hi 0", hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural Hi/Lo registers, for the multicycle CPU datapath. Executes MULT, MULTU, DIV and DIVU one bit per cycle under a start/busy/done handshake. Raises a div-by-zero flag for the control FSM's exception path. Also accepts MTHI/MTLO-style direct writes.

Parameters:
WIDTH, 32, operand and Hi/Lo width in bits (≥4).
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden).

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  launch operation; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
a  in  WIDTH  multiplicand / dividend; sampled with start
b  in  WIDTH  multiplier / divisor; sampled with start
flush  in  1  synchronous abort of an in-flight operation
hi_we  in  1  direct write of Hi from wdata
lo_we  in  1  direct write of Lo from wdata
wdata  in  WIDTH  direct-write data
busy  out  1  operation in flight
done  out  1  one-cycle completion pulse
div_zero  out  1  one-cycle pulse: DIV/DIVU with b==0
hi  out  WIDTH  Hi register (product high half / remainder)
lo  out  WIDTH  Lo register (product low half / quotient)

Behaviour:
- Reset (asynchronous): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; counter and internal operand registers = 0.
- States: IDLE, RUN, FIN, DZ.
- IDLE, start=1 at edge k:
  - Latch op.
  - For signed ops, latch |a| and |b| and the result sign bits; for unsigned ops, latch a and b as-is.
  - If the op is a divide and b==0: go to DZ.
  - Otherwise: counter=WIDTH-1, go to RUN.
- busy=1 whenever state≠IDLE.
- RUN: one iteration per edge.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing 1 quotient bit per edge.
  - At counter==0, go to FIN. RUN lasts exactly WIDTH edges.
- FIN, at edge k+WIDTH+1:
  - Apply sign fix-up and write hi/lo.
  - done=1 for exactly the following cycle; return to IDLE.
  - Start-to-done latency is WIDTH+1 edges.
- DZ, at edge k+1: div_zero=1 and done=1 for one cycle; hi/lo unchanged; return to IDLE.
- Arithmetic results:
  - MULT: {hi,lo} = signed a×b, two's complement, 2*WIDTH bits.
  - MULTU: {hi,lo} = unsigned a×b.
  - DIV: lo = quotient truncated toward zero; hi = remainder, whose sign follows the dividend.
  - DIV overflow (a=MIN, b=−1): lo=MIN (wraps), hi=0; no flag raised.
  - DIVU: unsigned quotient and remainder.
- Handshake:
  - start while busy is ignored; no queueing.
  - done and div_zero never assert in the same cycle as a new start being accepted into RUN. done returns to 0 in the cycle after its pulse.
  - A new start may be issued in the cycle done is high (state is IDLE). It is accepted.
- Direct writes:
  - hi_we/lo_we take effect only in IDLE; ignored while busy.
  - If start and hi_we/lo_we are both asserted in IDLE, the write takes effect at that edge. The operation later overwrites hi/lo at FIN.
- flush:
  - In RUN, FIN or DZ: return to IDLE at that edge, with no done, no div_zero, and hi/lo unchanged.
  - flush has priority over FIN completion.
  - In IDLE, flush has priority over start, so start is dropped.
- Reset mid-operation: asynchronous clear to the reset values above; the operation is lost.

Decomposition:
- Package muldiv_pkg holds:
  - op typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  - state typedef enum {S_IDLE, S_RUN, S_FIN, S_DZ};
  - helper function abs_val.
- Sub-module muldiv_step: purely combinational single iteration. It takes accumulator, operand and mode, and returns the next accumulator. This allows the step to be unit-tested in isolation.
- muldiv_unit holds the FSM, counter, sign fix-up and Hi/Lo registers.

Test Plan:
- WIDTH=32, MULT a=0xFFFFFFFD (−3), b=5, start at edge k → busy=1 from k; done pulse after edge k+33; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; then back-to-back start in the done cycle with MULT 0×7 → accepted; hi=lo=0 after a further 33 edges.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- Preload hi=0x1234 and lo=0x5678 via hi_we/lo_we, then DIVU a=7, b=0 → done=div_zero=1 after edge k+1 only; hi=0x1234 and lo=0x5678 unchanged.
- DIVU 100/7 started; start with new operands at k+5 → ignored; flush at k+10 → busy=0 next cycle, no done, hi/lo unchanged. Repeat without flush, with hi_we at k+5 → ignored; result lo=14, hi=2.
- Assert reset at k+12 of a MULT → busy, done, hi and lo all 0 immediately (asynchronous). After release, a new MULT 6×7 gives lo=42, hi=0.
